// File: rtl/alu_issue_arbiter_pkg.sv
// Shared core types for the ALU issue arbiter: machine word, shift amount
// and the ALU operation encoding. Codes 4'd14 and 4'd15 are unassigned and
// make the ALU produce zero.
package alu_issue_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  shamt_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alufunc_t;

endpackage

// File: rtl/alu_issue_arbiter_alu.sv
// Combinational ALU shared by both issue pipes. Shifts take the amount from
// a[4:0] and shift b; LUI places b[15:0] in the upper half. Signed overflow is
// reported only for ADD/SUB.
module alu_issue_arbiter_alu
  import alu_issue_arbiter_pkg::*;
(
  input  word_t    i_a,
  input  word_t    i_b,
  input  alufunc_t i_func,
  output word_t    o_c,
  output logic     o_of
);

  logic [32:0] w_sum;
  logic [32:0] w_dif;
  shamt_t      w_sh;

  assign w_sum = {i_a[31], i_a} + {i_b[31], i_b};
  assign w_dif = {i_a[31], i_a} - {i_b[31], i_b};
  assign w_sh  = i_a[4:0];

  // Select the result and overflow flag for the requested operation
  always_comb begin
    o_c  = 32'd0;
    o_of = 1'b0;
    case (i_func)
      ALU_ADD:  begin o_c = w_sum[31:0]; o_of = w_sum[32] ^ w_sum[31]; end
      ALU_ADDU: o_c = w_sum[31:0];
      ALU_SUB:  begin o_c = w_dif[31:0]; o_of = w_dif[32] ^ w_dif[31]; end
      ALU_SUBU: o_c = w_dif[31:0];
      ALU_AND:  o_c = i_a & i_b;
      ALU_OR:   o_c = i_a | i_b;
      ALU_XOR:  o_c = i_a ^ i_b;
      ALU_NOR:  o_c = ~(i_a | i_b);
      ALU_SLT:  o_c = {31'd0, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_c = {31'd0, (i_a < i_b)};
      ALU_SLL:  o_c = i_b << w_sh;
      ALU_SRL:  o_c = i_b >> w_sh;
      ALU_SRA:  o_c = $signed(i_b) >>> w_sh;
      ALU_LUI:  o_c = {i_b[15:0], 16'd0};
      default:  begin o_c = 32'd0; o_of = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_issue_arbiter_arb_rr2.sv
// Two-way round-robin grant. On a tie the pipe named by r_rr_ptr wins; after
// every accept the pointer moves to the pipe that did not win, so the other
// requester gets the next tie.
module alu_issue_arbiter_arb_rr2 (
  input  logic clk,
  input  logic resetn,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_accept,
  output logic o_grant
);

  logic r_rr_ptr;

  // Grant: a lone requester wins outright, a tie follows the pointer
  always_comb begin
    o_grant = 1'b0;
    if (i_req0 && i_req1) begin
      o_grant = r_rr_ptr;
    end else begin
      o_grant = i_req1;
    end
  end

  // Pointer advances only when an operation is actually accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= 1'b0;
    end else if (i_accept) begin
      r_rr_ptr <= ~o_grant;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between issue pipes 0 and 1 and registers the result, the
// overflow flag, the tag and the issuing pipe in a single valid/ready output
// stage. Build option ALU_ARB_RR_EN selects round-robin tie breaking;
// without it pipe 0 always wins a tie.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  word_t            in0_a,
  input  word_t            in0_b,
  input  alufunc_t         in0_func,
  input  logic [TAG_W-1:0] in0_tag,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  word_t            in1_a,
  input  word_t            in1_b,
  input  alufunc_t         in1_func,
  input  logic [TAG_W-1:0] in1_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            out_c,
  output logic             out_of,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_port
);

  typedef struct packed {
    word_t            c;
    logic             of;
    logic [TAG_W-1:0] tag;
    logic             port;
  } out_stage_t;

  out_stage_t       r_out;
  logic             r_out_valid;

  logic             w_stage_free;
  logic             w_issue_ok;
  logic             w_grant;
  logic             w_accept;
  word_t            w_a;
  word_t            w_b;
  alufunc_t         w_func;
  logic [TAG_W-1:0] w_tag;
  word_t            w_c;
  logic             w_of;

  assign w_stage_free = !r_out_valid || out_ready;
  assign w_issue_ok   = w_stage_free && !flush;

`ifdef ALU_ARB_RR_EN
  alu_issue_arbiter_arb_rr2 u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .i_req0   (in0_valid),
    .i_req1   (in1_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );
`else
  // Fixed priority: pipe 1 only gets the ALU when pipe 0 is not asking
  assign w_grant = in1_valid && !in0_valid;
`endif

  assign in0_ready = w_issue_ok && !w_grant;
  assign in1_ready = w_issue_ok && w_grant;
  assign w_accept  = (in0_valid && in0_ready) || (in1_valid && in1_ready);

  // Steer the granted pipe's operands, function and tag into the ALU
  always_comb begin
    w_a    = in0_a;
    w_b    = in0_b;
    w_func = in0_func;
    w_tag  = in0_tag;
    if (w_grant) begin
      w_a    = in1_a;
      w_b    = in1_b;
      w_func = in1_func;
      w_tag  = in1_tag;
    end else begin
      w_a    = in0_a;
      w_b    = in0_b;
      w_func = in0_func;
      w_tag  = in0_tag;
    end
  end

  alu_issue_arbiter_alu u_alu (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_func (w_func),
    .o_c    (w_c),
    .o_of   (w_of)
  );

  // Output stage: flush empties it, an accept loads it, a taken result
  // without a replacement empties it; data is kept when the stage drains
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out.c     <= w_c;
      r_out.of    <= w_of;
      r_out.tag   <= w_tag;
      r_out.port  <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_c     = r_out.c;
  assign out_of    = r_out.of;
  assign out_tag   = r_out.tag;
  assign out_port  = r_out.port;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a scoreboard: each accepted
// operation's expected result is queued when it is issued and compared when
// it appears on the output stage. Works with or without ALU_ARB_RR_EN.
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] c;
    logic        of;
    logic [3:0]  tag;
    logic        port;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic [31:0] in0_a, in0_b, in1_a, in1_b;
  alufunc_t    in0_func, in1_func;
  logic [3:0]  in0_tag, in1_tag;
  logic        flush;
  logic        out_valid, out_ready, out_of, out_port;
  logic [31:0] out_c;
  logic [3:0]  out_tag;

  int          checks;
  int          errors;
  exp_t        sb[$];
  exp_t        m_last;
  logic        m_valid;
  logic        m_rr;
  logic        m_grant;
  logic        seq[4];
  int          n0, n1;

  alu_issue_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b),
    .in0_func(in0_func), .in0_tag(in0_tag),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b),
    .in1_func(in1_func), .in1_tag(in1_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_of(out_of), .out_tag(out_tag), .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: {of, c}
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input alufunc_t f);
    logic signed [32:0] sa, sb_, s;
    sa = {a[31], a};
    sb_ = {b[31], b};
    case (f)
      ALU_ADD:  begin s = sa + sb_; return {s[32] != s[31], s[31:0]}; end
      ALU_SUB:  begin s = sa - sb_; return {s[32] != s[31], s[31:0]}; end
      ALU_ADDU: return {1'b0, a + b};
      ALU_SUBU: return {1'b0, a - b};
      ALU_AND:  return {1'b0, a & b};
      ALU_OR:   return {1'b0, a | b};
      ALU_XOR:  return {1'b0, a ^ b};
      ALU_NOR:  return {1'b0, ~(a | b)};
      ALU_SLT:  return {1'b0, 31'd0, sa < sb_};
      ALU_SLTU: return {1'b0, 31'd0, a < b};
      ALU_SLL:  return {1'b0, b << a[4:0]};
      ALU_SRL:  return {1'b0, b >> a[4:0]};
      ALU_SRA:  return {1'b0, 32'($signed(b) >>> a[4:0])};
      ALU_LUI:  return {1'b0, b[15:0], 16'd0};
      default:  return 33'd0;
    endcase
  endfunction

  // One clock of stimulus: check readies mid-cycle, queue the expected
  // result of any accept, then compare the output stage after the edge.
  task automatic step();
    logic free, g, acc, fl, ordy;
    logic [32:0] r;
    exp_t e;
    @(negedge clk);
    fl   = flush;
    ordy = out_ready;
    free = !m_valid || ordy;
    if (in0_valid && in1_valid) g = RR ? m_rr : 1'b0;
    else                        g = in1_valid && !in0_valid;
    chk("in0_ready", 32'(in0_ready), 32'(free && !fl && !g));
    chk("in1_ready", 32'(in1_ready), 32'(free && !fl && g));
    acc = free && !fl && (in0_valid || in1_valid);
    m_grant = g;
    if (acc) begin
      r = g ? alu_ref(in1_a, in1_b, in1_func) : alu_ref(in0_a, in0_b, in0_func);
      e.c = r[31:0];
      e.of = r[32];
      e.tag = g ? in1_tag : in0_tag;
      e.port = g;
      sb.push_back(e);
      if (RR) m_rr = !g;
    end
    @(posedge clk);
    #1;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_last = sb.pop_front();
    end else if (ordy) m_valid = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_c", out_c, m_last.c);
    chk("out_of", 32'(out_of), 32'(m_last.of));
    chk("out_tag", 32'(out_tag), 32'(m_last.tag));
    chk("out_port", 32'(out_port), 32'(m_last.port));
  endtask

  initial begin
    checks = 0; errors = 0;
    m_valid = 1'b0; m_rr = 1'b0; m_last = '0; m_grant = 1'b0;
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_a = 32'd0; in0_b = 32'd0; in0_func = ALU_ADD; in0_tag = 4'd0;
    in1_a = 32'd0; in1_b = 32'd0; in1_func = ALU_ADD; in1_tag = 4'd0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_c", out_c, 32'd0);
    chk("rst_of", 32'(out_of), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_port", 32'(out_port), 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Both pipes requesting for four cycles
    n0 = 0; n1 = 0;
    in0_valid = 1'b1; in0_func = ALU_OR;  in0_a = 32'h0000_00F0; in0_b = 32'h0000_000F;
    in1_valid = 1'b1; in1_func = ALU_XOR; in1_a = 32'hFFFF_0000; in1_b = 32'h0F0F_0F0F;
    for (int i = 0; i < 4; i++) begin
      in0_tag = 4'(1 + n0);
      in1_tag = 4'(9 + n1);
      step();
      seq[i] = out_port;
      if (m_grant) n1++; else n0++;
    end
    for (int i = 0; i < 4; i++) chk("tie_port_seq", 32'(seq[i]), RR ? 32'(i % 2) : 32'd0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();

    // Signed overflow on ADD, none on ADDU
    in0_valid = 1'b1; in0_func = ALU_ADD; in0_a = 32'h7FFF_FFFF; in0_b = 32'h0000_0001; in0_tag = 4'd3;
    step();
    chk("add_c", out_c, 32'h8000_0000);
    chk("add_of", 32'(out_of), 32'd1);
    chk("add_port", 32'(out_port), 32'd0);
    in0_func = ALU_ADDU; in0_tag = 4'd4;
    step();
    chk("addu_c", out_c, 32'h8000_0000);
    chk("addu_of", 32'(out_of), 32'd0);

    // Back-pressure: result held for three cycles with both pipes waiting
    in0_func = ALU_OR; in0_a = 32'h0000_1234; in0_b = 32'd0; in0_tag = 4'd5;
    step();
    out_ready = 1'b0; in1_valid = 1'b1; in0_tag = 4'd6; in1_tag = 4'd10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_c", out_c, 32'h0000_1234);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();

    // Flush beats a stalled result and a pending request
    in0_valid = 1'b1; in0_func = ALU_AND; in0_a = 32'hFF00_FF00; in0_b = 32'h0F0F_0F0F; in0_tag = 4'd7;
    step();
    out_ready = 1'b0; in0_valid = 1'b0; in1_valid = 1'b1; flush = 1'b1;
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    in0_tag = 4'd8; in1_tag = 4'd13;
    step();
    chk("post_flush_port", 32'(out_port), RR ? 32'd1 : 32'd0);
    in0_valid = 1'b0;

    // ALU functions through pipe 1
    in1_func = ALU_SRA; in1_a = 32'd4; in1_b = 32'h8000_0000; in1_tag = 4'd1;
    step();
    chk("sra_c", out_c, 32'hF800_0000);
    in1_func = ALU_LUI; in1_a = 32'd0; in1_b = 32'h0000_ABCD; in1_tag = 4'd2;
    step();
    chk("lui_c", out_c, 32'hABCD_0000);
    in1_func = ALU_SUB; in1_a = 32'h8000_0000; in1_b = 32'h0000_0001; in1_tag = 4'd3;
    step();
    chk("sub_of", 32'(out_of), 32'd1);
    chk("sub_c", out_c, 32'h7FFF_FFFF);
    in1_func = ALU_SUBU; in1_tag = 4'd4;
    step();
    chk("subu_of", 32'(out_of), 32'd0);
    in1_func = alufunc_t'(4'd15); in1_tag = 4'd5;
    step();
    chk("unk_c", out_c, 32'd0);
    in1_func = ALU_SLT; in1_a = 32'hFFFF_FFFF; in1_b = 32'd1; in1_tag = 4'd6;
    step();
    in1_func = ALU_SLL; in1_a = 32'd8; in1_b = 32'h0000_00FF; in1_tag = 4'd7;
    step();
    chk("sll_c", out_c, 32'h0000_FF00);

    // Asynchronous reset while a result is held
    in1_valid = 1'b0; in0_valid = 1'b1; in0_func = ALU_XOR; in0_a = 32'd5; in0_b = 32'd3; in0_tag = 4'd2;
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2; resetn = 1'b0; in0_valid = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_c", out_c, 32'd0);
    chk("arst_of", 32'(out_of), 32'd0);
    chk("arst_tag", 32'(out_tag), 32'd0);
    chk("arst_port", 32'(out_port), 32'd0);
    m_valid = 1'b0; m_rr = 1'b0; m_last = '0; sb.delete();
    @(negedge clk); resetn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_tag = 4'd1; in1_tag = 4'd9;
    in0_func = ALU_OR; in1_func = ALU_XOR;
    step();
    chk("post_rst_port", 32'(out_port), 32'd0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
